writeback_stage: RTL and testbench

- Final pipeline stage, directly downstream of the memory stage; consumes its 58-bit output bundle.
- Holds the MEM/WB stage register and selects write-back data (memory vs ALU).
- Drives the register-file write port and the output-port latch.
- Assembles 32-bit PC values from two consecutive 16-bit stack pops (RET/RTI/interrupt return) and restores flags.

---
 rtl/writeback_stage.sv | 169 ++++++++++++++++
 tb/tb_writeback_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Write-back stage: MEM/WB register, result mux, output-port latch, two-beat PC
// reassembly and flag restore. Define WB_RETIRE_CNT_EN to build the retire counter.
module writeback_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int FLAG_W = 4
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [3*DATA_W+REG_AW+6:0] WritebackInput,
  input  logic                       InValid,
  input  logic                       Stall,
  input  logic                       Flush,
  output logic                       RegWriteEn,
  output logic [REG_AW-1:0]          RegWriteAddr,
  output logic [DATA_W-1:0]          RegWriteData,
  output logic [DATA_W-1:0]          OutPort,
  output logic                       PcLoad,
  output logic [2*DATA_W-1:0]        PcValue,
  output logic                       FlagsLoad,
  output logic [FLAG_W-1:0]          FlagsValue,
  output logic                       SeqError,
  output logic [15:0]                RetireCount
);

  localparam int RDST_LSB = 7;
  localparam int ALU_LSB  = RDST_LSB + REG_AW;
  localparam int MEM_LSB  = ALU_LSB + DATA_W;
  localparam int PASS_LSB = MEM_LSB + DATA_W;
  localparam int IN_W     = PASS_LSB + DATA_W;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_HAVE_HI = 1'b1;

  // PassData is not consumed here, so only the lower fields are registered.
  logic [PASS_LSB-1:0] r_stage;
  logic                r_valid;
  logic [DATA_W-1:0]   r_out_port;
  logic [DATA_W-1:0]   r_hi;
  logic [0:0]          r_state;

  logic                w_reg_write;
  logic                w_mem_to_reg;
  logic                w_out_en;
  logic                w_pop_hi;
  logic                w_pop_lo;
  logic                w_flag_restore;
  logic [REG_AW-1:0]   w_rdst;
  logic [DATA_W-1:0]   w_alu_out;
  logic [DATA_W-1:0]   w_mem_data;
  logic [DATA_W-1:0]   w_wb_data;
  logic                w_active;
  logic [0:0]          w_state_next;
  logic                w_hi_load;
  logic                w_pc_load;
  logic                w_seq_err;
  logic                w_unused;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_stage <= '0;
      r_valid <= 1'b0;
    end else if (Flush) begin
      r_valid <= 1'b0;
    end else if (!Stall) begin
      r_stage <= WritebackInput[PASS_LSB-1:0];
      r_valid <= InValid;
    end
  end

  assign w_reg_write    = r_stage[0];
  assign w_mem_to_reg   = r_stage[1];
  assign w_out_en       = r_stage[2];
  // A bundle carrying both pop flags behaves as the low-half pop.
  assign w_pop_lo       = r_stage[4];
  assign w_pop_hi       = r_stage[3] & ~r_stage[4];
  assign w_flag_restore = r_stage[5];
  assign w_rdst         = r_stage[ALU_LSB-1:RDST_LSB];
  assign w_alu_out      = r_stage[MEM_LSB-1:ALU_LSB];
  assign w_mem_data     = r_stage[PASS_LSB-1:MEM_LSB];
  assign w_unused       = ^{WritebackInput[IN_W-1:PASS_LSB], r_stage[6]};

  assign w_wb_data    = w_mem_to_reg ? w_mem_data : w_alu_out;
  assign w_active     = r_valid & ~Stall & ~Flush;

  assign RegWriteEn   = r_valid & w_reg_write & ~Stall;
  assign RegWriteAddr = w_rdst;
  assign RegWriteData = w_wb_data;
  assign OutPort      = r_out_port;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_out_port <= '0;
    end else if (r_valid && w_out_en && !Stall) begin
      r_out_port <= w_wb_data;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hi_load    = 1'b0;
    w_pc_load    = 1'b0;
    w_seq_err    = 1'b0;
    if (w_active) begin
      case (r_state)
        S_IDLE: begin
          if (w_pop_hi) begin
            w_hi_load    = 1'b1;
            w_state_next = S_HAVE_HI;
          end else if (w_pop_lo) begin
            w_seq_err = 1'b1;
          end
        end
        S_HAVE_HI: begin
          if (w_pop_lo) begin
            w_pc_load    = 1'b1;
            w_state_next = S_IDLE;
          end else if (w_pop_hi) begin
            w_seq_err = 1'b1;
            w_hi_load = 1'b1;
          end else begin
            // Anything else between the two pops breaks the sequence.
            w_seq_err    = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
    if (Flush) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_hi_load) begin
        r_hi <= w_mem_data;
      end
    end
  end

  assign PcLoad     = w_pc_load;
  assign PcValue    = {r_hi, w_mem_data};
  assign SeqError   = w_seq_err;
  assign FlagsLoad  = w_active & w_flag_restore;
  assign FlagsValue = w_mem_data[FLAG_W-1:0];

`ifdef WB_RETIRE_CNT_EN
  logic [15:0] r_retire_count;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_retire_count <= '0;
    end else if (w_active && (r_retire_count != 16'hFFFF)) begin
      r_retire_count <= r_retire_count + 16'd1;
    end
  end

  assign RetireCount = r_retire_count;
`else
  assign RetireCount = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: hand-derived vector table, multi-cycle stall and
// asynchronous-reset sequences, then random traffic against a queue-based model.
module tb_writeback_stage;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [57:0] WritebackInput;
  logic        InValid, Stall, Flush;
  logic        RegWriteEn;
  logic [2:0]  RegWriteAddr;
  logic [15:0] RegWriteData, OutPort;
  logic        PcLoad;
  logic [31:0] PcValue;
  logic        FlagsLoad;
  logic [3:0]  FlagsValue;
  logic        SeqError;
  logic [15:0] RetireCount;

  writeback_stage dut (
    .CLK(CLK), .Reset(Reset), .WritebackInput(WritebackInput),
    .InValid(InValid), .Stall(Stall), .Flush(Flush),
    .RegWriteEn(RegWriteEn), .RegWriteAddr(RegWriteAddr), .RegWriteData(RegWriteData),
    .OutPort(OutPort), .PcLoad(PcLoad), .PcValue(PcValue),
    .FlagsLoad(FlagsLoad), .FlagsValue(FlagsValue), .SeqError(SeqError),
    .RetireCount(RetireCount)
  );

  always #5 CLK = ~CLK;

`ifdef WB_RETIRE_CNT_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  // Control field bits as 6-bit values, bit k here is Ctrl[k+1].
  localparam logic [5:0] M2R  = 6'h01;
  localparam logic [5:0] OUTE = 6'h02;
  localparam logic [5:0] HI   = 6'h04;
  localparam logic [5:0] LO   = 6'h08;
  localparam logic [5:0] FLG  = 6'h10;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [57:0] bnd(input logic [15:0] mem, input logic [15:0] alu,
                                      input logic [2:0] rdst, input logic [5:0] ctrl,
                                      input logic rw);
    logic [15:0] pass;
    pass = 16'($urandom);
    return {pass, mem, alu, rdst, ctrl, rw};
  endfunction

  task automatic drive(input logic [57:0] b, input logic v, input logic st, input logic fl);
    WritebackInput = b;
    InValid        = v;
    Stall          = st;
    Flush          = fl;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [15:0] mem, alu;
    logic [2:0]  rdst;
    logic [5:0]  ctrl;
    logic        rw, v, st, fl;
    logic        e_rwe;
    logic [2:0]  e_addr;
    logic [15:0] e_data, e_out;
    logic        e_pcl;
    logic [31:0] e_pcv;
    logic        e_seq, e_fll;
    logic [3:0]  e_flv;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] mem, alu, input logic [2:0] rdst,
                              input logic [5:0] ctrl, input logic rw, v, st, fl,
                              input logic e_rwe, input logic [2:0] e_addr,
                              input logic [15:0] e_data, e_out, input logic e_pcl,
                              input logic [31:0] e_pcv, input logic e_seq, e_fll,
                              input logic [3:0] e_flv);
    vec_t r;
    r.mem = mem; r.alu = alu; r.rdst = rdst; r.ctrl = ctrl;
    r.rw = rw; r.v = v; r.st = st; r.fl = fl;
    r.e_rwe = e_rwe; r.e_addr = e_addr; r.e_data = e_data; r.e_out = e_out;
    r.e_pcl = e_pcl; r.e_pcv = e_pcv; r.e_seq = e_seq; r.e_fll = e_fll; r.e_flv = e_flv;
    return r;
  endfunction

  // Reference model: stage contents, pending high halves as a queue.
  logic        m_valid, m_rw;
  logic [15:0] m_mem, m_alu, m_out, last_hi;
  logic [2:0]  m_rdst;
  logic [5:0]  m_ctrl;
  logic [15:0] hiq[$];
  int          m_ret;

  vec_t tbl[22];

  initial begin
    int pcl_count;
    Reset = 1'b0;
    drive(bnd(16'h1, 16'h2, 3'd1, OUTE | HI, 1'b1), 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #2;
    chk("reset_rwe", RegWriteEn, 0);
    chk("reset_out", OutPort, 0);
    chk("reset_pcl", PcLoad, 0);
    chk("reset_seq", SeqError, 0);
    chk("reset_fll", FlagsLoad, 0);
    chk("reset_ret", RetireCount, 0);
    drive(58'd0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    Reset = 1'b1;
    next_cycle();

    tbl[0]  = mk(16'h0000, 16'h1234, 3'd5, 6'h00, 1, 1, 0, 0,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(16'hBEEF, 16'h1111, 3'd2, M2R,   1, 1, 0, 0,  1, 5, 16'h1234, 16'h0000, 0, 0, 0, 0, 0);
    tbl[2]  = mk(16'h0000, 16'h00FF, 3'd0, OUTE,  0, 1, 0, 0,  1, 2, 16'hBEEF, 16'h0000, 0, 0, 0, 0, 0);
    tbl[3]  = mk(16'h0001, 16'h0000, 3'd0, HI,    0, 1, 0, 0,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    tbl[4]  = mk(16'h0000, 16'h0000, 3'd0, 6'h00, 0, 0, 0, 0,  0, 0, 16'h0000, 16'h00FF, 0, 0, 0, 0, 0);
    tbl[5]  = mk(16'h2345, 16'h0000, 3'd0, LO,    0, 1, 0, 0,  0, 0, 16'h0000, 16'h00FF, 0, 0, 0, 0, 0);
    tbl[6]  = mk(16'h000A, 16'h0000, 3'd0, FLG,   0, 1, 0, 0,  0, 0, 16'h0000, 16'h00FF, 1, 32'h0001_2345, 0, 0, 0);
    tbl[7]  = mk(16'h0001, 16'h0000, 3'd0, LO,    0, 1, 0, 0,  0, 0, 16'h0000, 16'h00FF, 0, 0, 0, 1, 4'hA);
    tbl[8]  = mk(16'h00AB, 16'h0000, 3'd0, HI,    0, 1, 0, 0,  0, 0, 16'h0000, 16'h00FF, 0, 0, 1, 0, 0);
    tbl[9]  = mk(16'h0000, 16'h0007, 3'd3, 6'h00, 1, 1, 0, 0,  0, 0, 16'h0000, 16'h00FF, 0, 0, 0, 0, 0);
    tbl[10] = mk(16'h5555, 16'h0000, 3'd0, LO,    0, 1, 0, 0,  1, 3, 16'h0007, 16'h00FF, 0, 0, 1, 0, 0);
    tbl[11] = mk(16'h0C0C, 16'h0000, 3'd0, HI,    0, 1, 0, 0,  0, 0, 16'h0000, 16'h00FF, 0, 0, 1, 0, 0);
    tbl[12] = mk(16'h0000, 16'h0000, 3'd0, 6'h00, 0, 0, 0, 0,  0, 0, 16'h0000, 16'h00FF, 0, 0, 0, 0, 0);
    tbl[13] = mk(16'h0000, 16'h0000, 3'd0, 6'h00, 0, 0, 0, 1,  0, 0, 16'h0000, 16'h00FF, 0, 0, 0, 0, 0);
    tbl[14] = mk(16'h0D0D, 16'h0000, 3'd0, LO,    0, 1, 0, 0,  0, 0, 16'h0000, 16'h00FF, 0, 0, 0, 0, 0);
    tbl[15] = mk(16'h0000, 16'h0000, 3'd0, 6'h00, 0, 0, 0, 0,  0, 0, 16'h0000, 16'h00FF, 0, 0, 1, 0, 0);
    tbl[16] = mk(16'h0000, 16'h0009, 3'd6, 6'h00, 1, 1, 0, 0,  0, 0, 16'h0000, 16'h00FF, 0, 0, 0, 0, 0);
    tbl[17] = mk(16'h0000, 16'h0000, 3'd0, 6'h00, 0, 0, 1, 0,  0, 0, 16'h0000, 16'h00FF, 0, 0, 0, 0, 0);
    tbl[18] = mk(16'h0000, 16'h0000, 3'd0, 6'h00, 0, 0, 0, 0,  1, 6, 16'h0009, 16'h00FF, 0, 0, 0, 0, 0);
    tbl[19] = mk(16'h4444, 16'h0000, 3'd0, HI|LO, 0, 1, 0, 0,  0, 0, 16'h0000, 16'h00FF, 0, 0, 0, 0, 0);
    tbl[20] = mk(16'h0000, 16'h0000, 3'd0, 6'h00, 0, 0, 0, 0,  0, 0, 16'h0000, 16'h00FF, 0, 0, 1, 0, 0);
    tbl[21] = mk(16'h0000, 16'h0000, 3'd0, 6'h00, 0, 0, 0, 0,  0, 0, 16'h0000, 16'h00FF, 0, 0, 0, 0, 0);

    for (int i = 0; i < 22; i++) begin
      drive(bnd(tbl[i].mem, tbl[i].alu, tbl[i].rdst, tbl[i].ctrl, tbl[i].rw),
            tbl[i].v, tbl[i].st, tbl[i].fl);
      $display("row %0d rwe=%0b addr=%0d data=%h out=%h pcl=%0b pcv=%h seq=%0b fll=%0b flv=%h",
               i, RegWriteEn, RegWriteAddr, RegWriteData, OutPort, PcLoad, PcValue,
               SeqError, FlagsLoad, FlagsValue);
      chk($sformatf("row%0d_rwe", i), RegWriteEn, tbl[i].e_rwe);
      if (tbl[i].e_rwe) begin
        chk($sformatf("row%0d_addr", i), RegWriteAddr, tbl[i].e_addr);
        chk($sformatf("row%0d_data", i), RegWriteData, tbl[i].e_data);
      end
      chk($sformatf("row%0d_out", i), OutPort, tbl[i].e_out);
      chk($sformatf("row%0d_pcl", i), PcLoad, tbl[i].e_pcl);
      if (tbl[i].e_pcl) chk($sformatf("row%0d_pcv", i), PcValue, tbl[i].e_pcv);
      chk($sformatf("row%0d_seq", i), SeqError, tbl[i].e_seq);
      chk($sformatf("row%0d_fll", i), FlagsLoad, tbl[i].e_fll);
      if (tbl[i].e_fll) chk($sformatf("row%0d_flv", i), FlagsValue, tbl[i].e_flv);
      next_cycle();
    end

    // High pop, low pop held under a three-cycle stall: one PcLoad only.
    drive(bnd(16'h1111, 16'h0, 3'd0, HI, 1'b0), 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(bnd(16'h2222, 16'h0, 3'd0, LO, 1'b0), 1'b1, 1'b0, 1'b0);
    chk("stall_hi_seq", SeqError, 0);
    next_cycle();
    pcl_count = 0;
    for (int k = 0; k < 3; k++) begin
      drive(bnd(16'h0, 16'h0, 3'd0, 6'h00, 1'b0), 1'b0, 1'b1, 1'b0);
      $display("stall cycle %0d pcl=%0b seq=%0b", k, PcLoad, SeqError);
      chk($sformatf("stall%0d_pcl", k), PcLoad, 0);
      chk($sformatf("stall%0d_seq", k), SeqError, 0);
      next_cycle();
    end
    drive(bnd(16'h0, 16'h0, 3'd0, 6'h00, 1'b0), 1'b0, 1'b0, 1'b0);
    $display("stall release pcl=%0b pcv=%h", PcLoad, PcValue);
    chk("stall_rel_pcl", PcLoad, 1);
    chk("stall_rel_pcv", PcValue, 32'h1111_2222);
    chk("stall_rel_seq", SeqError, 0);
    next_cycle();
    chk("stall_after_pcl", PcLoad, 0);

    // Asynchronous reset in the middle of a write-back / PcLoad cycle.
    drive(bnd(16'hAAAA, 16'h0, 3'd0, HI, 1'b0), 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(bnd(16'hBBBB, 16'hCCCC, 3'd1, LO | OUTE, 1'b1), 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(bnd(16'h0, 16'h0, 3'd0, 6'h00, 1'b0), 1'b0, 1'b0, 1'b0);
    $display("pre-reset rwe=%0b pcl=%0b out=%h", RegWriteEn, PcLoad, OutPort);
    chk("prerst_rwe", RegWriteEn, 1);
    chk("prerst_pcl", PcLoad, 1);
    chk("prerst_out", OutPort, 16'h00FF);
    #2;
    Reset = 1'b0;
    #1;
    $display("async reset rwe=%0b pcl=%0b out=%h", RegWriteEn, PcLoad, OutPort);
    chk("arst_rwe", RegWriteEn, 0);
    chk("arst_pcl", PcLoad, 0);
    chk("arst_out", OutPort, 0);
    chk("arst_ret", RetireCount, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    next_cycle();

    // Random traffic against the model; the first ten bundles are plain active ops.
    m_valid = 1'b0; m_rw = 1'b0; m_mem = '0; m_alu = '0; m_rdst = '0; m_ctrl = '0;
    m_out = '0; last_hi = '0; m_ret = 0;
    hiq.delete();
    for (int i = 0; i < 500; i++) begin
      logic [57:0] b;
      logic        v, st, fl, act, lo, hi, e_pcl, e_seq, e_fll;
      logic [15:0] data;
      if (i < 10) begin
        b  = bnd(16'($urandom), 16'($urandom), 3'($urandom), 6'h00, 1'b1);
        v  = 1'b1; st = 1'b0; fl = 1'b0;
      end else begin
        b  = bnd(16'($urandom), 16'($urandom), 3'($urandom), 6'($urandom), 1'($urandom));
        v  = ($urandom_range(0, 3) != 0);
        st = (i >= 12) && ($urandom_range(0, 4) == 0);
        fl = (i >= 12) && ($urandom_range(0, 9) == 0);
      end
      drive(b, v, st, fl);

      act   = m_valid && !st && !fl;
      lo    = m_ctrl[3];
      hi    = m_ctrl[2] && !lo;
      data  = m_ctrl[0] ? m_mem : m_alu;
      e_pcl = act && lo && (hiq.size() != 0);
      e_seq = act && ((hiq.size() == 0) ? lo : !lo);
      e_fll = act && m_ctrl[4];
      $display("txn %0d v=%0b st=%0b fl=%0b rwe=%0b pcl=%0b seq=%0b fll=%0b out=%h ret=%0d",
               i, v, st, fl, RegWriteEn, PcLoad, SeqError, FlagsLoad, OutPort, RetireCount);
      chk("rnd_rwe", RegWriteEn, m_valid && m_rw && !st);
      if (m_valid) begin
        chk("rnd_addr", RegWriteAddr, m_rdst);
        chk("rnd_data", RegWriteData, data);
        chk("rnd_pcv", PcValue, {last_hi, m_mem});
      end
      chk("rnd_out", OutPort, m_out);
      chk("rnd_pcl", PcLoad, e_pcl);
      chk("rnd_seq", SeqError, e_seq);
      chk("rnd_fll", FlagsLoad, e_fll);
      if (e_fll) chk("rnd_flv", FlagsValue, m_mem[3:0]);
      chk("rnd_ret", RetireCount, RET_EN ? m_ret : 0);
      if (i == 11) chk("retire_after_10", RetireCount, RET_EN ? 32'd10 : 32'd0);

      next_cycle();
      if (act) begin
        if (lo) begin
          hiq.delete();
        end else if (hi) begin
          hiq.delete();
          hiq.push_back(m_mem);
          last_hi = m_mem;
        end else begin
          hiq.delete();
        end
        if (m_ret < 65535) m_ret++;
      end
      if (fl) hiq.delete();
      if (m_valid && m_ctrl[1] && !st) m_out = data;
      if (fl) begin
        m_valid = 1'b0;
      end else if (!st) begin
        m_valid = v;
        m_rw    = b[0];
        m_ctrl  = b[6:1];
        m_rdst  = b[9:7];
        m_alu   = b[25:10];
        m_mem   = b[41:26];
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
